// File: rtl/ahb_mgr_if.sv
// AHB-Lite manager bridge: turns single-word client requests into one SINGLE/NONSEQ
// word transfer at a time, with registered bus outputs and a one-cycle completion pulse.
module ahb_mgr_if #(
  parameter int AHB_ADDR_WIDTH    = 32,
  parameter int AHB_DATA_WIDTH    = 64,
  parameter int CLIENT_DATA_WIDTH = 32
) (
  input  logic                          hclk_i,
  input  logic                          hreset_i,
  input  logic                          m_req_i,
  input  logic                          m_req_is_wr_i,
  input  logic [AHB_ADDR_WIDTH-1:0]     m_addr_i,
  input  logic [CLIENT_DATA_WIDTH-1:0]  m_wr_data_i,
  output logic                          m_req_stall_o,
  output logic                          m_rd_ack_o,
  output logic [CLIENT_DATA_WIDTH-1:0]  m_rd_data_o,
  output logic                          m_wr_ack_o,
  output logic                          m_err_o,
  output logic [AHB_ADDR_WIDTH-1:0]     haddr_o,
  output logic [2:0]                    hburst_o,
  output logic [3:0]                    hprot_o,
  output logic [2:0]                    hsize_o,
  output logic [1:0]                    htrans_o,
  output logic                          hwrite_o,
  output logic [AHB_DATA_WIDTH-1:0]     hwdata_o,
  output logic [AHB_DATA_WIDTH/8-1:0]   hwstrb_o,
  input  logic [AHB_DATA_WIDTH-1:0]     hrdata_i,
  input  logic                          hready_i,
  input  logic                          hresp_i
);

  localparam int NLANES = AHB_DATA_WIDTH / CLIENT_DATA_WIDTH;
  localparam int LANE_W = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_MERR} state_t;

  state_t                          r_state, w_next;
  logic [AHB_ADDR_WIDTH-1:0]       r_haddr;
  logic [1:0]                      r_htrans;
  logic                            r_hwrite;
  logic [AHB_DATA_WIDTH-1:0]       r_hwdata;
  logic [AHB_DATA_WIDTH/8-1:0]     r_hwstrb;
  logic [CLIENT_DATA_WIDTH-1:0]    r_wdata;
  logic [CLIENT_DATA_WIDTH-1:0]    r_rd_data;
  logic [LANE_W-1:0]               r_lane;
  logic                            r_is_wr;
  logic                            r_err;
  logic [LANE_W-1:0]               w_lane;
  logic [AHB_DATA_WIDTH/8-1:0]     w_strb;
  logic [CLIENT_DATA_WIDTH-1:0]    w_rd_lane;
  logic                            w_misaligned;
  logic                            w_ack;

  generate
    if (NLANES > 1) begin : g_lane
      assign w_lane = m_addr_i[LANE_W+1:2];
    end else begin : g_nolane
      assign w_lane = '0;
    end
  endgenerate

  assign w_misaligned = (m_addr_i[1:0] != 2'b00);

  always_comb begin
    w_strb    = '0;
    w_rd_lane = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (r_lane == LANE_W'(i)) begin
        w_strb[4*i +: 4] = 4'hF;
        w_rd_lane        = hrdata_i[CLIENT_DATA_WIDTH*i +: CLIENT_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (m_req_i) w_next = w_misaligned ? S_MERR : S_ADDR;
      S_ADDR:  if (hready_i) w_next = S_DATA;
      S_DATA:  if (hready_i) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      S_MERR:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk_i or posedge hreset_i) begin
    if (hreset_i) begin
      r_haddr   <= '0;
      r_htrans  <= HTRANS_IDLE;
      r_hwrite  <= 1'b0;
      r_hwdata  <= '0;
      r_hwstrb  <= '0;
      r_wdata   <= '0;
      r_rd_data <= '0;
      r_lane    <= '0;
      r_is_wr   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (m_req_i) begin
          r_is_wr <= m_req_is_wr_i;
          if (w_misaligned) begin
            r_err <= 1'b1;
            if (!m_req_is_wr_i) r_rd_data <= '0;
          end else begin
            r_err    <= 1'b0;
            r_haddr  <= m_addr_i;
            r_htrans <= HTRANS_NONSEQ;
            r_hwrite <= m_req_is_wr_i;
            r_wdata  <= m_wr_data_i;
            r_lane   <= w_lane;
          end
        end
        S_ADDR: if (hready_i) begin
          r_htrans <= HTRANS_IDLE;
          r_hwdata <= {NLANES{r_wdata}};
          r_hwstrb <= w_strb;
        end
        // hresp_i is only meaningful together with hready_i, which also skips the
        // first cycle of a two-cycle ERROR response.
        S_DATA: if (hready_i) begin
          r_hwstrb <= '0;
          r_err    <= hresp_i;
          if (!r_is_wr) r_rd_data <= hresp_i ? '0 : w_rd_lane;
        end
        default: ;
      endcase
    end
  end

  assign w_ack         = (r_state == S_RESP) || (r_state == S_MERR);
  assign m_req_stall_o = (r_state != S_IDLE);
  assign m_rd_ack_o    = w_ack && !r_is_wr;
  assign m_wr_ack_o    = w_ack && r_is_wr;
  assign m_err_o       = w_ack && r_err;
  assign m_rd_data_o   = r_rd_data;

  assign haddr_o  = r_haddr;
  assign htrans_o = r_htrans;
  assign hwrite_o = r_hwrite;
  assign hwdata_o = r_hwdata;
  assign hwstrb_o = r_hwstrb;
  assign hburst_o = 3'b000;
  assign hprot_o  = 4'b0011;
  assign hsize_o  = 3'b010;

endmodule
